// File: rtl/sound_fx_sequencer.sv
// Multi-channel square-wave sound-effect sequencer driving a single 1-bit speaker.
// Each channel plays a tone for a set number of prescaler ticks. The lowest active channel index is heard.
module sound_fx_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 15,
  parameter int DUR_W    = 10,
  parameter int TICK_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       trig,
  input  logic [NUM_CH*DIV_W-1:0] half_period,
  input  logic [NUM_CH*DUR_W-1:0] duration,
  output logic                    speaker,
  output logic [NUM_CH-1:0]       active,
  output logic                    busy
);

  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } ch_state_e;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [DIV_W-1:0]  hp_q    [NUM_CH];
  logic [DIV_W-1:0]  hp_d    [NUM_CH];
  logic [DIV_W-1:0]  tone_q  [NUM_CH];
  logic [DIV_W-1:0]  tone_d  [NUM_CH];
  logic [DUR_W-1:0]  rem_q   [NUM_CH];
  logic [DUR_W-1:0]  rem_d   [NUM_CH];
  logic [NUM_CH-1:0] phase_q, phase_d;

  logic              speaker_q, speaker_d;
  logic              sel_phase;

  // The prescaler is free-running, so a trigger never realigns it to the tick.
  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  // NOTE: every variable gets its default at the top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      hp_d[i]    = hp_q[i];
      tone_d[i]  = tone_q[i];
      rem_d[i]   = rem_q[i];
      phase_d[i] = phase_q[i];

      if (trig[i] && (half_period[i*DIV_W +: DIV_W] != '0)
                  && (duration[i*DUR_W +: DUR_W] != '0)) begin
        // A retrigger restarts the tone and the duration, and it overrides a tick or an expiry in the same cycle.
        state_d[i] = PLAY;
        hp_d[i]    = half_period[i*DIV_W +: DIV_W];
        tone_d[i]  = half_period[i*DIV_W +: DIV_W] - DIV_W'(1);
        rem_d[i]   = duration[i*DUR_W +: DUR_W];
        phase_d[i] = 1'b0;
      end else if (state_q[i] == PLAY) begin
        if (tone_q[i] == '0) begin
          phase_d[i] = ~phase_q[i];
          tone_d[i]  = hp_q[i] - DIV_W'(1);
        end else begin
          tone_d[i] = tone_q[i] - DIV_W'(1);
        end

        if (tick) begin
          if (rem_q[i] == DUR_W'(1)) begin
            state_d[i] = IDLE;
            rem_d[i]   = '0;
            phase_d[i] = 1'b0;
          end else begin
            rem_d[i] = rem_q[i] - DUR_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state_q[i] == PLAY);
    end
  end

  assign busy = |active;

  // The scan runs from the highest index down, so the lowest active channel is written last and wins.
  always_comb begin
    sel_phase = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active[i]) sel_phase = phase_q[i];
    end
    speaker_d = enable & busy & sel_phase;
  end

  // NOTE: sequential state uses non-blocking assignments only. The reset is synchronous and clears every register, the per-channel arrays included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      phase_q    <= '0;
      speaker_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        hp_q[i]    <= '0;
        tone_q[i]  <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      speaker_q  <= speaker_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        hp_q[i]    <= hp_d[i];
        tone_q[i]  <= tone_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  assign speaker = speaker_q;

endmodule

// File: tb/tb_sound_fx_sequencer.sv
// Directed bench for sound_fx_sequencer with NUM_CH=4, DIV_W=8, DUR_W=4 and TICK_DIV=10.
// Cycle k counts edges after the last reset edge, so duration ticks land on edges k = 10, 20, 30, and so on.
module tb_sound_fx_sequencer;

  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 8;
  localparam int DUR_W    = 4;
  localparam int TICK_DIV = 10;

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic [NUM_CH-1:0]       trig;
  logic [NUM_CH*DIV_W-1:0] half_period;
  logic [NUM_CH*DUR_W-1:0] duration;
  logic                    speaker;
  logic [NUM_CH-1:0]       active;
  logic                    busy;

  int n_vec = 0;
  int n_err = 0;

  sound_fx_sequencer #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .trig        (trig),
    .half_period (half_period),
    .duration    (duration),
    .speaker     (speaker),
    .active      (active),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs are set before the call and outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [17:1] spk3;

    rst_n       = 1'b0;
    enable      = 1'b1;
    trig        = 4'hF;
    half_period = {8'd1, 8'd1, 8'd1, 8'd1};
    duration    = {4'd1, 4'd1, 4'd1, 4'd1};

    // Reset overrides a trigger on every channel.
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_speaker", {31'd0, speaker}, 32'd0);
      check("rst_active",  {28'd0, active},  32'd0);
      check("rst_busy",    {31'd0, busy},    32'd0);
    end

    // Test 2: ch0 with hp=3 and dur=2. Ticks at edges 10 and 20 end it at edge 20.
    rst_n       = 1'b1;
    trig        = '0;
    half_period = {8'd0, 8'd0, 8'd0, 8'd3};
    duration    = {4'd0, 4'd0, 4'd0, 4'd2};
    for (int k = 1; k <= 21; k++) begin
      trig = (k == 1) ? 4'b0001 : 4'b0000;
      step();
      if (k == 1) begin
        check("t2_spk",  {31'd0, speaker}, 32'd0);
      end else begin
        check("t2_spk",  {31'd0, speaker}, 32'(((k - 2) / 3) % 2));
      end
      check("t2_active", {28'd0, active}, (k < 20) ? 32'd1 : 32'd0);
      check("t2_busy",   {31'd0, busy},   (k < 20) ? 32'd1 : 32'd0);
    end

    // Test 3: ch1 with hp=5. ch0 (hp=2, dur=1) starts at edge 4 and expires at tick 10, then ch1 phase is heard again.
    do_reset();
    half_period = {8'd0, 8'd0, 8'd5, 8'd2};
    duration    = {4'd0, 4'd0, 4'd15, 4'd1};
    spk3        = 17'b10000010011000000;
    for (int k = 1; k <= 17; k++) begin
      trig = (k == 1) ? 4'b0010 : (k == 4) ? 4'b0001 : 4'b0000;
      step();
      check("t3_spk", {31'd0, speaker}, {31'd0, spk3[k]});
      check("t3_active", {28'd0, active},
            (k < 4) ? 32'h2 : (k < 10) ? 32'h3 : 32'h2);
    end

    // Test 4: ch2 with hp=4 and dur=3. It is retriggered at edge 29 and again at edge 50, where an expiry and a tick coincide.
    do_reset();
    half_period = {8'd0, 8'd4, 8'd0, 8'd0};
    duration    = {4'd0, 4'd3, 4'd0, 4'd0};
    for (int k = 1; k <= 81; k++) begin
      trig = (k == 1 || k == 29 || k == 50) ? 4'b0100 : 4'b0000;
      step();
      check("t4_active", {28'd0, active}, (k < 80) ? 32'h4 : 32'h0);
      if (k == 25) check("t4_spk25", {31'd0, speaker}, 32'd1);
      if (k == 30) check("t4_spk30", {31'd0, speaker}, 32'd0);
      if (k == 33) check("t4_spk33", {31'd0, speaker}, 32'd0);
      if (k == 34) check("t4_spk34", {31'd0, speaker}, 32'd1);
      if (k == 81) check("t4_spk81", {31'd0, speaker}, 32'd0);
    end

    // Test 5: ch3 triggers with dur=0 or hp=0 are ignored, both while idle and while playing.
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      case (k)
        1:       begin half_period = {8'd5, 24'd0}; duration = {4'd0, 12'd0}; trig = 4'b1000; end
        3:       begin half_period = {8'd0, 24'd0}; duration = {4'd4, 12'd0}; trig = 4'b1000; end
        5:       begin half_period = {8'd2, 24'd0}; duration = {4'd1, 12'd0}; trig = 4'b1000; end
        7:       begin half_period = {8'd0, 24'd0}; duration = {4'd1, 12'd0}; trig = 4'b1000; end
        default: trig = 4'b0000;
      endcase
      step();
      if (k <= 4) begin
        check("t5_idle_active", {28'd0, active},  32'd0);
        check("t5_idle_spk",    {31'd0, speaker}, 32'd0);
      end
      if (k == 8)  check("t5_spk8",     {31'd0, speaker}, 32'd1);
      if (k == 9)  check("t5_active9",  {28'd0, active},  32'h8);
      if (k == 10) check("t5_active10", {28'd0, active},  32'h0);
      if (k == 11) check("t5_spk11",    {31'd0, speaker}, 32'd0);
    end

    // Test 6: ch0 with hp=3 is muted for edges 5 to 16 and keeps running silently.
    do_reset();
    half_period = {8'd0, 8'd0, 8'd0, 8'd3};
    duration    = {4'd0, 4'd0, 4'd0, 4'd15};
    for (int k = 1; k <= 20; k++) begin
      trig   = (k == 1) ? 4'b0001 : 4'b0000;
      enable = !(k >= 5 && k <= 16);
      step();
      if (k == 1 || (k >= 5 && k <= 16)) begin
        check("t6_spk_mute", {31'd0, speaker}, 32'd0);
      end else begin
        check("t6_spk", {31'd0, speaker}, 32'(((k - 2) / 3) % 2));
      end
      check("t6_active", {28'd0, active}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
